// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver with mid-bit sampling and start/stop validation.
// Defining UART_RX_PARITY_EN turns the frame into 8E1 with a parity check.
module uart_rx #(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       frame_error,
    output logic       parity_error,
    output logic       receiving
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q;
    logic          rxs;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          pbad_q, pbad_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          perr_q, perr_d;
    logic          recv_q, recv_d;
    logic          bit_end;
    logic          half_end;

    assign rxs      = sync_q[1];
    assign bit_end  = (cnt_q == LAST_CNT);
    assign half_end = (cnt_q == HALF_CNT);

    // State register, synchronizer, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            idx_q   <= '0;
            pbad_q  <= 1'b0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            recv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], rx};
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pbad_q  <= pbad_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            recv_q  <= recv_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!rxs) state_d = S_START;
            end
            S_START: begin
                if (half_end) state_d = rxs ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (bit_end && (idx_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
            S_PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (bit_end) state_d = S_STOP;
`else
                state_d = S_IDLE;
`endif
            end
            S_STOP: begin
                if (bit_end) state_d = rxs ? S_IDLE : S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (rxs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bit timing and data capture
    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        pbad_d  = pbad_q;
        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                pbad_d = 1'b0;
            end
            S_START: begin
                if (half_end) begin
                    cnt_d = '0;
                    idx_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[7:1]};
                    idx_d   = idx_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                    pbad_d = (rxs != (^shift_q));
`endif
                end
            end
            S_STOP: begin
                if (bit_end) cnt_d = '0;
            end
            S_WAIT_IDLE: begin
                cnt_d = '0;
            end
            default: cnt_d = '0;
        endcase
    end

    // Strobes fire on the stop sample and land in the cycle after it
    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
        recv_d  = (state_q != S_IDLE) && (state_d != S_IDLE);
        if ((state_q == S_STOP) && bit_end) begin
            if (!rxs) begin
                ferr_d = 1'b1;
            end else if (pbad_q) begin
                perr_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                data_d  = shift_q;
            end
        end
    end

    assign rx_data       = data_q;
    assign rx_data_valid = valid_q;
    assign frame_error   = ferr_q;
    assign parity_error  = perr_q;
    assign receiving     = recv_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: good frames, back-to-back,
// glitch rejection, break/frame error, mid-frame reset and (when enabled) parity.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       frame_error;
    logic       parity_error;
    logic       receiving;

    int tests = 0;
    int fails = 0;

    int         cyc = 0;
    int         vcnt = 0;
    int         fcnt = 0;
    int         pcnt = 0;
    int         t_last = 0;
    int         t_prev = 0;
    logic [7:0] d_last = 8'h00;
    logic [7:0] d_prev = 8'h00;
    logic [7:0] prev_data = 8'h00;
    logic       dbad = 1'b0;
    logic       xbad = 1'b0;

    int v0, f0, p0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (rx),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .frame_error   (frame_error),
        .parity_error  (parity_error),
        .receiving     (receiving)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_data_valid) begin
            vcnt   <= vcnt + 1;
            t_prev <= t_last;
            t_last <= cyc;
            d_prev <= d_last;
            d_last <= rx_data;
        end
        if (frame_error)  fcnt <= fcnt + 1;
        if (parity_error) pcnt <= pcnt + 1;
        if (rst_n && (rx_data !== prev_data) && !rx_data_valid) dbad <= 1'b1;
        if ((rx_data_valid & frame_error) | (rx_data_valid & parity_error) |
            (frame_error & parity_error)) xbad <= 1'b1;
        prev_data <= rx_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopv, input logic parv);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(parv);
`endif
        send_bit(stopv);
        rx = 1'b1;
    endtask

    initial begin
        // Reset state
        tick(4);
        check("rst_data",      32'(rx_data), 32'h00);
        check("rst_valid",     32'(rx_data_valid), 32'h0);
        check("rst_ferr",      32'(frame_error), 32'h0);
        check("rst_perr",      32'(parity_error), 32'h0);
        check("rst_receiving", 32'(receiving), 32'h0);
        rst_n = 1'b1;
        tick(20);

        // Single good frame
        send_frame(8'hA5, 1'b1, 1'b0);
        tick(20);
        check("a5_vcnt",  32'(vcnt), 32'd1);
        check("a5_data",  32'(rx_data), 32'hA5);
        check("a5_ferr",  32'(fcnt), 32'd0);
        check("a5_recv",  32'(receiving), 32'h0);

        // Back-to-back frames, no idle gap
        v0 = vcnt;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        tick(20);
        check("b2b_vcnt",  32'(vcnt - v0), 32'd2);
        check("b2b_first", 32'(d_prev), 32'h00);
        check("b2b_last",  32'(d_last), 32'hFF);
        check("b2b_gap",   32'(t_last - t_prev), 32'd160);
        check("b2b_data",  32'(rx_data), 32'hFF);

        // Short low glitch on an idle line
        v0 = vcnt;
        f0 = fcnt;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(2);
        check("glitch_recv_hi", 32'(receiving), 32'h1);
        tick(10);
        check("glitch_recv_lo", 32'(receiving), 32'h0);
        tick(20);
        check("glitch_vcnt", 32'(vcnt - v0), 32'd0);
        check("glitch_ferr", 32'(fcnt - f0), 32'd0);
        check("glitch_data", 32'(rx_data), 32'hFF);

        // Stop bit low followed by a long break
        v0 = vcnt;
        f0 = fcnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        tick(50 * CPB);
        check("brk_recv",  32'(receiving), 32'h1);
        rx = 1'b1;
        tick(20);
        check("brk_ferr",  32'(fcnt - f0), 32'd1);
        check("brk_vcnt",  32'(vcnt - v0), 32'd0);
        check("brk_data",  32'(rx_data), 32'hFF);
        check("brk_idle",  32'(receiving), 32'h0);
        send_frame(8'h11, 1'b1, 1'b0);
        tick(20);
        check("after_brk_vcnt", 32'(vcnt - v0), 32'd1);
        check("after_brk_data", 32'(rx_data), 32'h11);

        // Reset during data bit 4 of 0x5A
        v0 = vcnt;
        f0 = fcnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(v0 < 0 ? 1'b0 : 8'h5A >> i & 8'h01 ? 1'b1 : 1'b0);
        rx = 1'b1;
        tick(8);
        #3;
        rst_n = 1'b0;
        #1;
        check("mrst_data",  32'(rx_data), 32'h00);
        check("mrst_recv",  32'(receiving), 32'h0);
        check("mrst_valid", 32'(rx_data_valid), 32'h0);
        tick(3);
        rst_n = 1'b1;
        tick(CPB * 6);
        check("mrst_vcnt", 32'(vcnt - v0), 32'd0);
        check("mrst_ferr", 32'(fcnt - f0), 32'd0);
        send_frame(8'h77, 1'b1, 1'b0);
        tick(20);
        check("post_rst_vcnt", 32'(vcnt - v0), 32'd1);
        check("post_rst_data", 32'(rx_data), 32'h77);
        check("post_rst_ferr", 32'(fcnt - f0), 32'd0);

`ifdef UART_RX_PARITY_EN
        // Wrong then correct even parity for 0x03
        v0 = vcnt;
        p0 = pcnt;
        send_frame(8'h03, 1'b1, 1'b1);
        tick(20);
        check("par_bad_perr", 32'(pcnt - p0), 32'd1);
        check("par_bad_vcnt", 32'(vcnt - v0), 32'd0);
        check("par_bad_data", 32'(rx_data), 32'h77);
        send_frame(8'h03, 1'b1, 1'b0);
        tick(20);
        check("par_ok_vcnt", 32'(vcnt - v0), 32'd1);
        check("par_ok_data", 32'(rx_data), 32'h03);
        check("par_ok_perr", 32'(pcnt - p0), 32'd1);
`else
        p0 = 0;
        check("no_parity_strobe", 32'(pcnt - p0), 32'd0);
`endif

        check("data_only_on_valid", 32'(dbad), 32'h0);
        check("strobes_exclusive",  32'(xbad), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for the 8N1 link driven by `uart_tx`; the counterpart on the host-to-board direction. Oversamples the line with a bit-period counter, validates start and stop bits, and presents each received byte as a one-cycle strobe with held data. Sits between the `RS232_Rx` pin and any command logic, for example a counter-reset or threshold-set path feeding the Geiger counter.

## Interface
- `CLKS_PER_BIT`, 1250, system clocks per bit (12 MHz / 9600 baud); legal range ≥ 4.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `rx_data`  out  8  last good byte, LSB = first data bit received.
- `rx_data_valid`  out  1  one-cycle strobe: `rx_data` is newly updated.
- `frame_error`  out  1  one-cycle strobe: stop bit sampled low.
- `parity_error`  out  1  one-cycle strobe: parity mismatch (see Configuration).
- `receiving`  out  1  high whenever the FSM is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1). All logic uses the synchronized signal `rxs`.
- Bit counter width is $clog2(CLKS_PER_BIT). Data bit index is 3 bits.
- IDLE: counter = 0. When `rxs` = 0, go to START.
- START: count to CLKS_PER_BIT/2 − 1 (integer division), then sample `rxs`.
  - Sample = 0: go to DATA, clear counter and bit index.
  - Sample = 1: treat as a glitch and return to IDLE with no strobe.
- DATA: sample `rxs` when counter = CLKS_PER_BIT − 1, then clear the counter.
  - Shift the sample into a shift register, LSB first.
  - After bit index 7, go to PARITY if the macro is defined, else go to STOP.
- PARITY (macro only): sample one bit period later and compare with the even parity of the 8 data bits.
- STOP: sample one bit period later.
  - Sample = 1 and no parity mismatch: load `rx_data` from the shift register, pulse `rx_data_valid`, go to IDLE.
  - Sample = 1 with parity mismatch: pulse `parity_error`, leave `rx_data` unchanged, go to IDLE.
  - Sample = 0: pulse `frame_error`, leave `rx_data` unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until `rxs` = 1, then go to IDLE. A break condition therefore produces exactly one `frame_error` and no further frames.
- No consumer handshake exists. Bytes are never buffered. `rx_data` holds its value until the next good frame overwrites it (no overrun flag).
- Back-to-back frames are accepted: IDLE is re-entered mid-stop-bit, and a start edge arriving at the next bit boundary is detected.

## Timing
- Reset (async assert, sync-released by the system):
  - `rx_data` = 0x00; `rx_data_valid`, `frame_error`, `parity_error` = 0; `receiving` = 0.
  - FSM = IDLE; counter = 0; synchronizer = 1.
- Reset asserted mid-frame aborts the frame immediately with no strobe. After release, a line still low goes through START again.
- Falling edge on `rx` to START entry: 2 clocks (synchronizer) plus 1 clock.
- Start-bit centre sample: CLKS_PER_BIT/2 clocks after START entry. Each later sample follows CLKS_PER_BIT clocks after the previous one.
- `rx_data_valid`, `frame_error` and `parity_error` are registered, asserted for exactly 1 clock, in the clock after the stop sample. They are mutually exclusive.
- `rx_data` changes only in the same cycle that `rx_data_valid` is asserted.
- `receiving` rises 1 clock after START entry and falls with the strobe cycle.

## Configuration
- `UART_RX_PARITY_EN`, defined: frame is 8E1, with a PARITY state between DATA and STOP. `parity_error` is driven as described above.
- Not defined: frame is 8N1, the PARITY state is absent, and `parity_error` is tied to 0.

## Test plan
- Set CLKS_PER_BIT = 16, send 8N1 byte 0xA5 -> one `rx_data_valid` pulse, `rx_data` = 0xA5, no error strobes.
- Send 0x00 then 0xFF back-to-back with no idle gap -> two valid pulses 160 clocks apart, `rx_data` = 0x00 then 0xFF.
- Drive a 4-clock low glitch on an idle line -> no strobe, `receiving` low again within 12 clocks, `rx_data` unchanged.
- Send 0x3C with stop bit low, then hold the line low for 50 bit periods -> exactly one `frame_error`, `rx_data` keeps the previous value, next good frame 0x11 is received.
- Assert `rst_n` low during data bit 4 of frame 0x5A -> outputs return to reset values asynchronously, no strobe, next frame 0x77 is received correctly.
- With `UART_RX_PARITY_EN`, send 0x03 with parity 1 (wrong) -> `parity_error` pulse, no `rx_data_valid`; resend with parity 0 -> valid pulse, `rx_data` = 0x03.
